// File: rtl/jpeg_pkg.sv
// jpeg_pkg: shared mode codes, component ids, blocks-per-MCU constants and
// sequencer state encoding for the JPEG scan path.
package jpeg_pkg;
   localparam logic [1:0] MODE_444  = 2'b00;
   localparam logic [1:0] MODE_422  = 2'b01;
   localparam logic [1:0] MODE_420  = 2'b10;
   localparam logic [1:0] MODE_GRAY = 2'b11;
   localparam logic [1:0] COMP_Y  = 2'd0;
   localparam logic [1:0] COMP_CB = 2'd1;
   localparam logic [1:0] COMP_CR = 2'd2;
   localparam logic [2:0] BPM_444  = 3'd3;
   localparam logic [2:0] BPM_422  = 3'd4;
   localparam logic [2:0] BPM_420  = 3'd6;
   localparam logic [2:0] BPM_GRAY = 3'd1;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_DECODE,
      ST_HOLD,
      ST_RESTART,
      ST_DONE
   } state_t;
endpackage

// File: rtl/jpeg_mcu_sequencer_if.sv
// jpeg_mcu_sequencer_if: block descriptor handshake between the sequencer
// and the accumulator/serializer.
interface jpeg_mcu_sequencer_if #(
   parameter int DIM_W  = 16,
   parameter int COMP_W = 2
);
   logic              blk_valid;
   logic              blk_ready;
   logic [COMP_W-1:0] blk_comp;
   logic              blk_last_in_mcu;
   logic [DIM_W-1:0]  mcu_x;
   logic [DIM_W-1:0]  mcu_y;
   modport master (output blk_valid, blk_comp, blk_last_in_mcu, mcu_x, mcu_y, input blk_ready);
   modport slave  (input blk_valid, blk_comp, blk_last_in_mcu, mcu_x, mcu_y, output blk_ready);
endinterface

// File: rtl/jpeg_mcu_layout.sv
// jpeg_mcu_layout: decodes subsample mode and block index into component id,
// blocks per MCU and log2 of the MCU width/height.
module jpeg_mcu_layout import jpeg_pkg::*; #(
   parameter int COMP_W = 2
) (
   input  logic [1:0]        i_mode,
   input  logic [2:0]        i_blk_idx,
   output logic [COMP_W-1:0] o_comp,
   output logic [2:0]        o_bpm,
   output logic [2:0]        o_w_shift,
   output logic [2:0]        o_h_shift
);
   logic [2:0] w_cb_idx;
   // Chroma always occupies the final two slots: Cb then Cr.
   always_comb begin
      o_bpm     = i_mode == MODE_444 ? BPM_444 :
                  i_mode == MODE_422 ? BPM_422 :
                  i_mode == MODE_420 ? BPM_420 : BPM_GRAY;
      w_cb_idx  = o_bpm - 3'd2;
      o_comp    = (i_mode == MODE_GRAY || i_blk_idx < w_cb_idx) ? COMP_W'(COMP_Y) :
                  i_blk_idx == w_cb_idx ? COMP_W'(COMP_CB) : COMP_W'(COMP_CR);
      o_w_shift = (i_mode == MODE_422 || i_mode == MODE_420) ? 3'd4 : 3'd3;
      o_h_shift = i_mode == MODE_420 ? 3'd4 : 3'd3;
   end
endmodule

// File: rtl/jpeg_mcu_sequencer.sv
// jpeg_mcu_sequencer: scan-level controller walking blocks, MCUs and restart
// intervals of a multi-component, subsampled JPEG scan.
module jpeg_mcu_sequencer import jpeg_pkg::*; #(
   parameter int DIM_W  = 16,
   parameter int COMP_W = 2,
   parameter int RST_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start_scan,
   input  logic [DIM_W-1:0] i_img_width,
   input  logic [DIM_W-1:0] i_img_height,
   input  logic [1:0]       i_subsample_mode,
   input  logic [RST_W-1:0] i_restart_interval,
   input  logic             i_block_done,
   input  logic             i_restart_ack,
   jpeg_mcu_sequencer_if.master blk,
   output logic             o_decode_enable,
   output logic             o_dc_pred_reset,
   output logic             o_restart_req,
   output logic             o_busy,
   output logic             o_scan_done
);
   state_t            r_state, w_next;
   logic [DIM_W-1:0]  r_w, r_h, r_mcus_x, r_mcus_y, r_mcu_x, r_mcu_y;
   logic [1:0]        r_mode;
   logic [RST_W-1:0]  r_rst_int, r_int_cnt;
   logic [2:0]        r_blk_idx;
   logic [COMP_W-1:0] r_comp;
   logic              r_last, r_dcr;
   logic [COMP_W-1:0] w_comp;
   logic [2:0]        w_bpm, w_w_shift, w_h_shift;
   logic [DIM_W:0]    w_sum_x, w_sum_y;
   logic [DIM_W-1:0]  w_mcus_x, w_mcus_y;
   logic [RST_W-1:0]  w_int_nxt;
   logic              w_empty, w_last_blk, w_last_x, w_last_y, w_final, w_int_end, w_accept;
   jpeg_mcu_layout #(.COMP_W(COMP_W)) u_layout (
      .i_mode    (r_mode),
      .i_blk_idx (r_blk_idx),
      .o_comp    (w_comp),
      .o_bpm     (w_bpm),
      .o_w_shift (w_w_shift),
      .o_h_shift (w_h_shift)
   );
   // One extra bit keeps the ceil rounding from wrapping near the maximum size.
   assign w_sum_x    = {1'b0, r_w} + ((DIM_W+1)'(1) << w_w_shift) - (DIM_W+1)'(1);
   assign w_sum_y    = {1'b0, r_h} + ((DIM_W+1)'(1) << w_h_shift) - (DIM_W+1)'(1);
   assign w_mcus_x   = DIM_W'(w_sum_x >> w_w_shift);
   assign w_mcus_y   = DIM_W'(w_sum_y >> w_h_shift);
   assign w_empty    = r_w == '0 || r_h == '0;
   assign w_last_blk = r_blk_idx == w_bpm - 3'd1;
   assign w_last_x   = r_mcu_x == r_mcus_x - DIM_W'(1);
   assign w_last_y   = r_mcu_y == r_mcus_y - DIM_W'(1);
   assign w_final    = w_last_blk && w_last_x && w_last_y;
   assign w_int_nxt  = r_int_cnt + RST_W'(1);
   assign w_int_end  = w_last_blk && r_rst_int != '0 && w_int_nxt == r_rst_int;
   assign w_accept   = r_state == ST_HOLD && blk.blk_ready;
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:    w_next = i_start_scan ? ST_SETUP : ST_IDLE;
         ST_SETUP:   w_next = w_empty ? ST_DONE : ST_DECODE;
         ST_DECODE:  w_next = i_block_done ? ST_HOLD : ST_DECODE;
         ST_HOLD:    w_next = !w_accept ? ST_HOLD : w_final ? ST_DONE :
                              w_int_end ? ST_RESTART : ST_DECODE;
         ST_RESTART: w_next = i_restart_ack ? ST_DECODE : ST_RESTART;
         ST_DONE:    w_next = ST_IDLE;
         default:    w_next = ST_IDLE;
      endcase
   end
   assign o_decode_enable     = r_state == ST_DECODE;
   assign o_restart_req       = r_state == ST_RESTART;
   assign o_scan_done         = r_state == ST_DONE;
   assign o_busy              = r_state != ST_IDLE;
   assign o_dc_pred_reset     = r_state == ST_SETUP || r_dcr;
   assign blk.blk_valid       = r_state == ST_HOLD;
   assign blk.blk_last_in_mcu = r_state == ST_HOLD && r_last;
   assign blk.blk_comp        = r_comp;
   assign blk.mcu_x           = r_mcu_x;
   assign blk.mcu_y           = r_mcu_y;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_w       <= '0;
         r_h       <= '0;
         r_mode    <= '0;
         r_rst_int <= '0;
         r_mcus_x  <= '0;
         r_mcus_y  <= '0;
         r_mcu_x   <= '0;
         r_mcu_y   <= '0;
         r_int_cnt <= '0;
         r_blk_idx <= '0;
         r_comp    <= '0;
         r_last    <= 1'b0;
         r_dcr     <= 1'b0;
      end else begin
         r_state <= w_next;
         r_dcr   <= r_state == ST_RESTART && i_restart_ack;
         if (r_state == ST_IDLE && i_start_scan) begin
            r_w       <= i_img_width;
            r_h       <= i_img_height;
            r_mode    <= i_subsample_mode;
            r_rst_int <= i_restart_interval;
         end
         if (r_state == ST_SETUP) begin
            r_mcus_x  <= w_mcus_x;
            r_mcus_y  <= w_mcus_y;
            r_mcu_x   <= '0;
            r_mcu_y   <= '0;
            r_int_cnt <= '0;
            r_blk_idx <= '0;
         end
         if (r_state == ST_DECODE && i_block_done) begin
            r_comp <= w_comp;
            r_last <= w_last_blk;
         end
         // Position freezes on the final block so it still names the last MCU.
         if (w_accept && !w_final) begin
            r_blk_idx <= w_last_blk ? 3'd0 : r_blk_idx + 3'd1;
            if (w_last_blk) begin
               r_int_cnt <= w_int_nxt;
               r_mcu_x   <= w_last_x ? '0 : r_mcu_x + DIM_W'(1);
               if (w_last_x) r_mcu_y <= r_mcu_y + DIM_W'(1);
            end
         end
         if (r_state == ST_RESTART && i_restart_ack) r_int_cnt <= '0;
      end
   end
endmodule

// File: tb/tb_jpeg_mcu_sequencer.sv
// tb_jpeg_mcu_sequencer: scan table plus hand-written stall and reset cases;
// expected block descriptors come from a reference model queued at scan start.
module tb_jpeg_mcu_sequencer;
   localparam int DIM_W = 16;
   localparam int COMP_W = 2;
   localparam int RST_W = 16;
   logic clk = 0, rst_n = 1, start_scan = 0, block_done = 0, restart_ack = 0;
   logic [DIM_W-1:0] img_w = 0, img_h = 0;
   logic [RST_W-1:0] rint = 0;
   logic [1:0] mode = 0;
   logic decode_enable, dc_pred_reset, restart_req, busy, scan_done;
   jpeg_mcu_sequencer_if #(.DIM_W(DIM_W), .COMP_W(COMP_W)) bus ();
   jpeg_mcu_sequencer #(.DIM_W(DIM_W), .COMP_W(COMP_W), .RST_W(RST_W)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .i_start_scan       (start_scan),
      .i_img_width        (img_w),
      .i_img_height       (img_h),
      .i_subsample_mode   (mode),
      .i_restart_interval (rint),
      .i_block_done       (block_done),
      .i_restart_ack      (restart_ack),
      .blk                (bus),
      .o_decode_enable    (decode_enable),
      .o_dc_pred_reset    (dc_pred_reset),
      .o_restart_req      (restart_req),
      .o_busy             (busy),
      .o_scan_done        (scan_done)
   );
   always #5 clk = ~clk;
   typedef struct packed {
      logic [1:0]  comp;
      logic        last;
      logic [15:0] x;
      logic [15:0] y;
   } desc_t;
   typedef struct {
      int         w;
      int         h;
      logic [1:0] mode;
      int         ri;
      bit         rnd;
      int         exp_blk;
      int         exp_rst;
   } cfg_t;
   desc_t q[$];
   cfg_t  cfgs[7];
   int checks = 0, errors = 0;
   int cyc = 0, acc_cnt = 0, dc_cnt = 0, ack_cnt = 0, done_cnt = 0, viol = 0;
   int last_acc = 0, done_cyc = 0;
   bit prev_ack = 0;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask
   function automatic logic [63:0] outs();
      return 64'({decode_enable, bus.blk_valid, bus.blk_comp, bus.blk_last_in_mcu, bus.mcu_x,
                  bus.mcu_y, dc_pred_reset, restart_req, busy, scan_done});
   endfunction
   function automatic logic [1:0] comp_of(input logic [1:0] m, input int b);
      int c;
      c = m == 2'b11 ? 0 : m == 2'b00 ? b : m == 2'b01 ? (b < 2 ? 0 : b - 1) : (b < 4 ? 0 : b - 3);
      return 2'(c);
   endfunction
   function automatic int bpm_of(input logic [1:0] m);
      return m == 2'b00 ? 3 : m == 2'b01 ? 4 : m == 2'b10 ? 6 : 1;
   endfunction
   task automatic start(input int w, input int h, input logic [1:0] m, input int ri);
      int mw, mh, nx, ny, n;
      desc_t d;
      mw = (m == 2'b01 || m == 2'b10) ? 16 : 8;
      mh = m == 2'b10 ? 16 : 8;
      nx = (w + mw - 1) / mw;
      ny = (h + mh - 1) / mh;
      n = bpm_of(m);
      for (int y = 0; y < ny; y++)
         for (int x = 0; x < nx; x++)
            for (int b = 0; b < n; b++) begin
               d.comp = comp_of(m, b);
               d.last = b == n - 1;
               d.x = 16'(x);
               d.y = 16'(y);
               q.push_back(d);
            end
      acc_cnt = 0; dc_cnt = 0; ack_cnt = 0; done_cnt = 0; viol = 0; prev_ack = 0;
      @(posedge clk); #1;
      img_w = 16'(w); img_h = 16'(h); mode = m; rint = 16'(ri); start_scan = 1;
      @(posedge clk); #1;
      start_scan = 0;
      img_w = 16'($urandom); img_h = 16'($urandom); mode = 2'($urandom); rint = 16'($urandom);
   endtask
   task automatic sample();
      desc_t e;
      @(negedge clk);
      cyc++;
      if (bus.blk_valid && bus.blk_ready) begin
         acc_cnt++;
         last_acc = cyc;
         if (q.size() == 0) chk("extra_desc", 64'(1), 64'(0));
         else begin
            e = q.pop_front();
            chk("desc", 64'({bus.blk_comp, bus.blk_last_in_mcu, bus.mcu_x, bus.mcu_y}), 64'(e));
         end
      end
      if (prev_ack) chk("dc_after_ack", 64'(dc_pred_reset), 64'(1));
      prev_ack = restart_req && restart_ack;
      if (prev_ack) ack_cnt++;
      if (dc_pred_reset) dc_cnt++;
      if (decode_enable && (bus.blk_valid || restart_req)) viol++;
      if (scan_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   endtask
   task automatic drive(input bit rnd);
      @(posedge clk); #1;
      block_done    = rnd ? 1'($urandom_range(0, 1)) : decode_enable;
      bus.blk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      restart_ack   = rnd ? 1'($urandom_range(0, 1)) : restart_req;
   endtask
   task automatic run(input bit rnd, input int exp_blk, input int exp_rst);
      bit fin = 0;
      for (int i = 0; i < 4000 && !fin; i++) begin
         sample();
         if (scan_done) fin = 1;
         else drive(rnd);
      end
      chk("scan_done_seen", 64'(fin), 64'(1));
      chk("blocks", 64'(acc_cnt), 64'(exp_blk));
      chk("queue_left", 64'(q.size()), 64'(0));
      chk("restarts", 64'(ack_cnt), 64'(exp_rst));
      chk("dc_pulses", 64'(dc_cnt), 64'(exp_rst + 1));
      chk("exclusive", 64'(viol), 64'(0));
      if (exp_blk > 0) chk("done_gap", 64'(done_cyc - last_acc), 64'(1));
      drive(0);
      sample();
      chk("idle_after_done", 64'({busy, scan_done, decode_enable}), 64'(0));
   endtask
   initial begin
      int bad, n;
      cfgs[0] = '{16, 8, 2'b11, 0, 0, 2, 0};
      cfgs[1] = '{17, 17, 2'b10, 0, 1, 24, 0};
      cfgs[2] = '{32, 8, 2'b01, 1, 1, 8, 1};
      cfgs[3] = '{0, 8, 2'b00, 0, 0, 0, 0};
      cfgs[4] = '{24, 16, 2'b00, 2, 1, 18, 2};
      cfgs[5] = '{17, 9, 2'b01, 3, 1, 16, 1};
      cfgs[6] = '{16, 0, 2'b10, 0, 0, 0, 0};
      bus.blk_ready = 0;
      #2 rst_n = 0;
      sample();
      chk("reset_state", outs(), 64'(0));
      @(posedge clk); #1 rst_n = 1;
      for (int i = 0; i < 7; i++) begin
         start(cfgs[i].w, cfgs[i].h, cfgs[i].mode, cfgs[i].ri);
         run(cfgs[i].rnd, cfgs[i].exp_blk, cfgs[i].exp_rst);
      end
      // 4:4:4 8x8 with the consumer stalled for five HOLD cycles
      start(8, 8, 2'b00, 0);
      sample();
      @(posedge clk); #1 block_done = 0; bus.blk_ready = 0; restart_ack = 0;
      sample();
      chk("decode_on", 64'(decode_enable), 64'(1));
      @(posedge clk); #1 block_done = 1;
      sample();
      @(posedge clk); #1 block_done = 0;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         sample();
         if (!(bus.blk_valid && bus.blk_comp == 2'd0 && !decode_enable && !bus.blk_last_in_mcu)) bad++;
         @(posedge clk); #1 bus.blk_ready = i == 4;
      end
      chk("stall_hold", 64'(bad), 64'(0));
      sample();
      chk("accepted_after_stall", 64'(acc_cnt), 64'(1));
      @(posedge clk); #1 bus.blk_ready = 0;
      sample();
      chk("decode_after_accept", 64'(decode_enable), 64'(1));
      drive(0);
      run(0, 3, 0);
      // reset in the middle of a gray 64x8 scan, then a clean rescan
      start(64, 8, 2'b11, 0);
      for (int i = 0; i < 6; i++) begin
         sample();
         drive(1);
      end
      rst_n = 0;
      n = done_cnt;
      sample();
      chk("reset_mid_scan", outs(), 64'(0));
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         sample();
      end
      chk("reset_held", outs(), 64'(0));
      chk("no_done_in_reset", 64'(done_cnt), 64'(n));
      @(posedge clk); #1 rst_n = 1; block_done = 0; restart_ack = 0;
      q.delete();
      start(16, 8, 2'b11, 0);
      run(0, 2, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
